// File: rtl/gpio_conditioner.sv
// GPIO front end: tristate pads, synchroniser, counter debouncer, edge pulses
// and sticky interrupt-pending flags, one independent lane per channel.
module gpio_conditioner #(
    parameter int GPIO_WIDTH = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter logic [GPIO_WIDTH-1:0] RESET_VALUE = {GPIO_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    inout  wire  [GPIO_WIDTH-1:0] gpio,
    input  logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] gpio_output,
    output logic [GPIO_WIDTH-1:0] gpio_clean,
    output logic [GPIO_WIDTH-1:0] gpio_rise,
    output logic [GPIO_WIDTH-1:0] gpio_fall,
    input  logic [GPIO_WIDTH-1:0] irq_mask,
    input  logic [GPIO_WIDTH-1:0] irq_clear,
    output logic [GPIO_WIDTH-1:0] irq_pending,
    output logic                  irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0] raw;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] stable;
    logic [CNT_W-1:0]      cnt [GPIO_WIDTH];

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
        assign gpio[i] = gpio_oe[i] ? gpio_output[i] : 1'bz;
    end

    // Driven bits loop back from the SoC value so they share the same latency
    assign raw = (gpio_oe & gpio_output) | (~gpio_oe & gpio);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign stable = sync_q[SYNC_STAGES-1];

    // Any sample matching the current clean value restarts the count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpio_clean <= RESET_VALUE;
            gpio_rise  <= '0;
            gpio_fall  <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            gpio_rise <= '0;
            gpio_fall <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (stable[i] == gpio_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    gpio_clean[i] <= stable[i];
                    gpio_rise[i]  <= stable[i];
                    gpio_fall[i]  <= ~stable[i];
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A new event outranks a simultaneous clear so it is never lost
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_pending <= '0;
        end else begin
            irq_pending <= (irq_pending & ~irq_clear) | gpio_rise | gpio_fall;
        end
    end

    assign irq = |(irq_pending & irq_mask);

endmodule

// File: doc/gpio_conditioner.md
Name: gpio_conditioner

Overview:
- Parametrised GPIO front end for board tops.
- Replaces the single-flop button "debounce" and the ad-hoc per-bit tristate loops.
- Per channel: bidirectional pad handling, metastability synchroniser, counter-based debouncer, edge-detect pulses and sticky interrupt-pending flags.
- Sits between the board pads and the SoC GPIO inputs and interrupt logic.

Parameters:
- GPIO_WIDTH, 3: number of channels.
- SYNC_STAGES, 2: synchroniser flop depth; legal range 2..4.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before the clean value follows the pad (10 ms at 50 MHz); must be >= 1. Counter width is $clog2(DEBOUNCE_CYCLES+1).
- RESET_VALUE, {GPIO_WIDTH{1'b0}}: reset value of the synchroniser chain and the clean outputs, per bit.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- gpio  inout  GPIO_WIDTH  board pads.
- gpio_oe  input  GPIO_WIDTH  per-bit output enable from the SoC.
- gpio_output  input  GPIO_WIDTH  per-bit drive value from the SoC.
- gpio_clean  output  GPIO_WIDTH  synchronised, debounced input value.
- gpio_rise  output  GPIO_WIDTH  one-cycle pulse: gpio_clean bit went 0->1.
- gpio_fall  output  GPIO_WIDTH  one-cycle pulse: gpio_clean bit went 1->0.
- irq_mask  input  GPIO_WIDTH  per-bit interrupt enable.
- irq_clear  input  GPIO_WIDTH  per-bit write-1-to-clear of the pending flag.
- irq_pending  output  GPIO_WIDTH  sticky per-bit event flag.
- irq  output  1  OR of (irq_pending & irq_mask).

Behaviour:
- Pad (combinational per bit): gpio[i] = gpio_oe[i] ? gpio_output[i] : Z.
- Raw sample (combinational per bit): raw[i] = gpio_oe[i] ? gpio_output[i] : gpio[i]. Driven bits loop back through the same sync and debounce path.
- Synchroniser: SYNC_STAGES flops per bit, reset to RESET_VALUE[i]; the last stage is s[i].
- Debounce: per-bit counter cnt[i], reset 0. Each cycle:
  - s[i] == gpio_clean[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: gpio_clean[i] <= s[i], cnt <= 0.
  - Else: cnt <= cnt + 1.
- Latency: pad change to gpio_clean change = SYNC_STAGES + DEBOUNCE_CYCLES clock edges, provided the pad holds.
- Glitch rejection: any return of s[i] to gpio_clean[i] before the count completes resets cnt to 0; no output change, no pulse.
- DEBOUNCE_CYCLES = 1: clean follows s on the first differing edge.
- Edge pulses: gpio_rise and gpio_fall are registered and asserted exactly in the cycle gpio_clean holds its new value, for one cycle only.
  - Rise and fall on the same bit are never asserted together.
  - Bits are independent.
- Pending flags, per bit, reset 0:
  - Set on gpio_rise[i] | gpio_fall[i].
  - Cleared on irq_clear[i].
  - Set and clear in the same cycle: set wins (the event is not lost).
  - The mask does not gate setting; it only gates irq.
- irq: combinational from registered irq_pending and irq_mask; no additional latency.
- Reset, asynchronous, at any time, including mid-count:
  - sync flops = RESET_VALUE; gpio_clean = RESET_VALUE.
  - cnt = 0; gpio_rise = gpio_fall = 0; irq_pending = 0; irq = 0.
  - After reset release, a pad differing from RESET_VALUE produces a normal debounced transition and pulse.
- No wrap-around: the counter never exceeds DEBOUNCE_CYCLES-1.

Test Plan (GPIO_WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0):
1. Reset asserted mid-stream with pad[0]=1 and a count in progress -> all outputs 0 immediately (asynchronous); after release, gpio_clean[0] rises 6 edges later with a single gpio_rise[0] pulse.
2. Clean step on pad[1] 0->1 (oe=0), held -> gpio_clean[1]=1 exactly 6 edges after the change; gpio_rise[1] high for 1 cycle; irq_pending[1]=1.
3. Glitch on pad[2]: high 3 cycles, then low -> gpio_clean[2] stays 0; no rise/fall pulse; irq_pending stays 0.
4. Bounce pad[0]: 1,0,1,0 every 2 cycles, then steady 1 -> exactly one gpio_rise[0], 6 edges after the last edge; no fall pulse.
5. Output mode: oe[1]=1, gpio_output[1] 1->0 -> pad gpio[1] driven 0 in the same cycle; gpio_clean[1] falls 6 edges later with gpio_fall[1]; oe=0 -> pad floats Z.
6. Interrupt handling:
   - irq_mask=3'b010, events on bits 0 and 1 -> irq=1.
   - irq_clear=3'b010 -> irq=0 while irq_pending=3'b001.
   - irq_clear[0] in the same cycle as a new bit-0 event -> irq_pending[0] stays 1.
